// File: rtl/multiword_sub_sequencer_pkg.sv
// Shared definitions for the multi-word add/sub sequencer: state encoding and default geometry.
package multiword_sub_sequencer_pkg;

   localparam int unsigned DEFAULT_WORD_W    = 16;
   localparam int unsigned DEFAULT_NUM_WORDS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/multiword_sub_sequencer_word_add_slice.sv
// One WORD_W-bit adder slice (a + b + cin -> sum, cout), purely combinational.
module word_add_slice #(
   parameter int unsigned WORD_W = 16
) (
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              cin_i,
   output logic [WORD_W-1:0] sum_o,
   output logic              cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_sub_sequencer.sv
// Wide add/sub built from one word slice iterated LSW first with a registered carry chain.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module multiword_sub_sequencer
   import multiword_sub_sequencer_pkg::*;
#(
   parameter int unsigned WORD_W    = DEFAULT_WORD_W,
   parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS,
   localparam int unsigned TW       = WORD_W * NUM_WORDS
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_valid_i,
   output logic          start_ready_o,
   input  logic          op_sub_i,
   input  logic [TW-1:0] a_i,
   input  logic [TW-1:0] b_i,
   output logic [TW-1:0] result_o,
   output logic          carry_out_o,
   output logic          borrow_out_o,
   output logic          result_valid_o,
   input  logic          result_ready_i,
`ifdef OVERFLOW_FLAG_EN
   output logic          ovf_o,
`endif
   output logic          busy_o
);

   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              op_sub_q, op_sub_d;
   logic [TW-1:0]     a_q, a_d;
   logic [TW-1:0]     b_q, b_d;
   logic [TW-1:0]     result_q, result_d;
   logic              carry_out_q, carry_out_d;
   logic              borrow_out_q, borrow_out_d;
`ifdef OVERFLOW_FLAG_EN
   logic              ovf_q, ovf_d;
`endif

   logic [WORD_W-1:0] a_word, b_word, b_eff, sum_word;
   logic              cout_word;

   assign a_word = a_q[idx_q*WORD_W +: WORD_W];
   assign b_word = b_q[idx_q*WORD_W +: WORD_W];
   assign b_eff  = op_sub_q ? ~b_word : b_word;

   word_add_slice #(
      .WORD_W (WORD_W)
   ) u_slice (
      .a_i    (a_word),
      .b_i    (b_eff),
      .cin_i  (carry_q),
      .sum_o  (sum_word),
      .cout_o (cout_word)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      carry_d      = carry_q;
      op_sub_d     = op_sub_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      carry_out_d  = carry_out_q;
      borrow_out_d = borrow_out_q;
`ifdef OVERFLOW_FLAG_EN
      ovf_d        = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_valid_i) begin
               a_d      = a_i;
               b_d      = b_i;
               op_sub_d = op_sub_i;
               carry_d  = op_sub_i;  // +1 of two's complement enters as LSW carry-in
               idx_d    = '0;
               result_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[idx_q*WORD_W +: WORD_W] = sum_word;
            carry_d = cout_word;
            if (idx_q == LAST_IDX) begin
               idx_d        = '0;
               carry_out_d  = cout_word;
               borrow_out_d = op_sub_q & ~cout_word;
`ifdef OVERFLOW_FLAG_EN
               ovf_d = (a_word[WORD_W-1] == b_eff[WORD_W-1]) &&
                       (sum_word[WORD_W-1] != a_word[WORD_W-1]);
`endif
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (result_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         carry_q      <= 1'b0;
         op_sub_q     <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         carry_out_q  <= 1'b0;
         borrow_out_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         carry_q      <= carry_d;
         op_sub_q     <= op_sub_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         carry_out_q  <= carry_out_d;
         borrow_out_q <= borrow_out_d;
`ifdef OVERFLOW_FLAG_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign start_ready_o  = (state_q == ST_IDLE) && !rst_i;
   assign busy_o         = (state_q != ST_IDLE);
   assign result_valid_o = (state_q == ST_DONE);
   assign result_o       = result_q;
   assign carry_out_o    = carry_out_q;
   assign borrow_out_o   = borrow_out_q;
`ifdef OVERFLOW_FLAG_EN
   assign ovf_o          = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_sub_sequencer.sv
// Randomized self-checking bench for multiword_sub_sequencer against a whole-width arithmetic model.
module tb_multiword_sub_sequencer;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned NUM_WORDS = 4;
   localparam int unsigned TW        = WORD_W * NUM_WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_valid, start_ready, op_sub;
   logic [TW-1:0] a_in, b_in, result;
   logic          carry_out, borrow_out, result_valid, result_ready, busy;
`ifdef OVERFLOW_FLAG_EN
   logic          ovf;
`endif

   int n_total = 0;
   int n_bad   = 0;

   multiword_sub_sequencer #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_valid_i  (start_valid),
      .start_ready_o  (start_ready),
      .op_sub_i       (op_sub),
      .a_i            (a_in),
      .b_i            (b_in),
      .result_o       (result),
      .carry_out_o    (carry_out),
      .borrow_out_o   (borrow_out),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
`ifdef OVERFLOW_FLAG_EN
      .ovf_o          (ovf),
`endif
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain wide unsigned arithmetic plus textbook signed-overflow rules.
   task automatic model(input logic sub, input logic [TW-1:0] a, input logic [TW-1:0] b,
                        output logic [TW-1:0] r, output logic c, output logic bo,
                        output logic ov);
      logic [TW:0] full;
      if (sub) begin
         r  = a - b;
         bo = (a < b);
         c  = ~bo;
         ov = (a[TW-1] != b[TW-1]) && (r[TW-1] != a[TW-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         r    = full[TW-1:0];
         c    = full[TW];
         bo   = 1'b0;
         ov   = (a[TW-1] == b[TW-1]) && (r[TW-1] != a[TW-1]);
      end
   endtask

   task automatic scramble_inputs();
      a_in   = {$urandom, $urandom};
      b_in   = {$urandom, $urandom};
      op_sub = 1'($urandom_range(0, 1));
   endtask

   task automatic run_op(input string tag, input logic sub, input logic [TW-1:0] a,
                         input logic [TW-1:0] b, input int hold);
      logic [TW-1:0] er;
      logic          ec, eb, eo;
      int            cyc;
      model(sub, a, b, er, ec, eb, eo);
      cyc = 0;
      while (!start_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val({tag, ".ready"}, TW'(start_ready), TW'(1));
      start_valid = 1'b1;
      op_sub      = sub;
      a_in        = a;
      b_in        = b;
      @(posedge clk); #1;
      // Accepted; anything driven from here on must be ignored.
      cyc = 0;
      while (!result_valid && cyc < 20) begin
         check_val({tag, ".busy_run"}, TW'(busy), TW'(1));
         start_valid  = 1'($urandom_range(0, 1));
         result_ready = 1'($urandom_range(0, 1));
         scramble_inputs();
         @(posedge clk); #1;
         cyc++;
      end
      result_ready = 1'b0;
      check_val({tag, ".latency"}, TW'(cyc), TW'(NUM_WORDS));
      check_val({tag, ".result"}, result, er);
      check_val({tag, ".carry"}, TW'(carry_out), TW'(ec));
      check_val({tag, ".borrow"}, TW'(borrow_out), TW'(eb));
`ifdef OVERFLOW_FLAG_EN
      check_val({tag, ".ovf"}, TW'(ovf), TW'(eo));
`endif
      for (int i = 0; i < hold; i++) begin
         start_valid = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         scramble_inputs();
         @(posedge clk); #1;
         check_val({tag, ".hold_valid"}, TW'(result_valid), TW'(1));
         check_val({tag, ".hold_result"}, result, er);
         check_val({tag, ".hold_carry"}, TW'(carry_out), TW'(ec));
         check_val({tag, ".hold_sready"}, TW'(start_ready), TW'(0));
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      start_valid  = 1'b0;
      check_val({tag, ".post_valid"}, TW'(result_valid), TW'(0));
      check_val({tag, ".post_sready"}, TW'(start_ready), TW'(1));
      check_val({tag, ".post_result"}, result, er);
      @(posedge clk); #1;
      check_val({tag, ".no_phantom"}, TW'(busy), TW'(0));
   endtask

   function automatic logic [TW-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return TW'(1);
         3:       return {1'b1, {(TW-1){1'b0}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      start_valid  = 1'b0;
      op_sub       = 1'b0;
      a_in         = '0;
      b_in         = '0;
      result_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst.result", result, '0);
      check_val("rst.valid", TW'(result_valid), TW'(0));
      check_val("rst.busy", TW'(busy), TW'(0));
      check_val("rst.carry", TW'(carry_out), TW'(0));
      check_val("rst.borrow", TW'(borrow_out), TW'(0));
      rst = 1'b0;
      #1;
      check_val("rst.sready", TW'(start_ready), TW'(1));

      run_op("t1", 1'b1, 64'h0000_0000_0001_0000, 64'h1, 0);
      run_op("t2", 1'b1, 64'h0, 64'h1, 1);
      run_op("t3", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2);
      run_op("t4", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5);

      // Reset two cycles into RUN aborts the operation.
      @(posedge clk); #1;
      start_valid = 1'b1;
      op_sub      = 1'b0;
      a_in        = 64'hFFFF_0000_FFFF_0000;
      b_in        = 64'h0001_0001_0001_0001;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("t5.busy", TW'(busy), TW'(0));
      check_val("t5.valid", TW'(result_valid), TW'(0));
      check_val("t5.result", result, '0);
      check_val("t5.carry", TW'(carry_out), TW'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_val("t5.sready", TW'(start_ready), TW'(1));
      run_op("t5.after", 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002, 1);

`ifdef OVERFLOW_FLAG_EN
      run_op("t6.sub", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 0);
      run_op("t6.add", 1'b0, 64'h1, 64'h1, 0);
`endif

      for (int n = 0; n < 40; n++) begin
         run_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), pick_operand(),
                pick_operand(), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
